// File: rtl/sdram_rw_arbiter.sv
// Arbitrates one Avalon-MM SDRAM master between a read requester and a write requester.
// One transaction at a time, reads preferred, in-flight reads capped, writes protected from starvation.
module sdram_rw_arbiter #(
    parameter int unsigned ADDR_W          = 24,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned WR_STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_accept_o,
    output logic [31:0]       rd_data_o,
    output logic              rd_valid_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i,
    output logic              wr_accept_o,
    output logic [ADDR_W-1:0] sdaddress_o,
    output logic              sdread_o,
    output logic              sdwrite_o,
    output logic [31:0]       sdwritedata_o,
    input  logic [31:0]       sdreaddata_i,
    input  logic              sdreaddatavalid_i,
    input  logic              sdwaitrequest_i,
    output logic [4:0]        outstanding_o,
    output logic              idle_o,
    output logic              err_unexpected_o,
    output logic [31:0]       reads_issued_o,
    output logic [31:0]       writes_issued_o
);

    localparam logic [4:0] OutMax    = 5'(MAX_OUTSTANDING);
    localparam logic [7:0] StarveMax = 8'(WR_STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [4:0]        out_q, out_d;
    logic [7:0]        starve_q, starve_d;
    logic              rd_valid_q, rd_valid_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic              err_q, err_d;
    logic [31:0]       rd_cnt_q, rd_cnt_d;
    logic [31:0]       wr_cnt_q, wr_cnt_d;

    logic rd_accept, wr_accept, rd_ok, rdv_match;

    assign rd_accept = (state_q == StRead) && !sdwaitrequest_i;
    assign wr_accept = (state_q == StWrite) && !sdwaitrequest_i;
    assign rd_ok     = rd_req_i && (out_q < OutMax);
    // A return only counts if some read is in flight, including one accepted this cycle.
    assign rdv_match = sdreaddatavalid_i && ((out_q != 5'd0) || rd_accept);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        starve_d = starve_q;
        case (state_q)
            StIdle: begin
                if (wr_req_i && ((starve_q == StarveMax) || !rd_ok)) begin
                    state_d  = StWrite;
                    addr_d   = wr_addr_i;
                    wdata_d  = wr_data_i;
                    starve_d = 8'd0;
                end else if (rd_ok) begin
                    state_d = StRead;
                    addr_d  = rd_addr_i;
                    if (wr_req_i) begin
                        starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 8'd1;
                    end else begin
                        starve_d = 8'd0;
                    end
                end
            end
            StRead:  if (!sdwaitrequest_i) state_d = StIdle;
            StWrite: if (!sdwaitrequest_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_d = out_q;
        case ({rd_accept, rdv_match})
            2'b10:   out_d = out_q + 5'd1;
            2'b01:   out_d = out_q - 5'd1;
            default: out_d = out_q;
        endcase
        err_d      = err_q | (sdreaddatavalid_i && !rdv_match);
        rd_valid_d = rdv_match;
        rd_data_d  = rdv_match ? sdreaddata_i : rd_data_q;
        rd_cnt_d   = rd_accept ? rd_cnt_q + 32'd1 : rd_cnt_q;
        wr_cnt_d   = wr_accept ? wr_cnt_q + 32'd1 : wr_cnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            out_q      <= '0;
            starve_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            err_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            out_q      <= out_d;
            starve_q   <= starve_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end

    assign rd_accept_o      = rd_accept;
    assign wr_accept_o      = wr_accept;
    assign sdread_o         = (state_q == StRead);
    assign sdwrite_o        = (state_q == StWrite);
    assign sdaddress_o      = addr_q;
    assign sdwritedata_o    = wdata_q;
    assign rd_valid_o       = rd_valid_q;
    assign rd_data_o        = rd_data_q;
    assign outstanding_o    = out_q;
    assign idle_o           = (state_q == StIdle) && (out_q == 5'd0) && !rd_req_i && !wr_req_i;
    assign err_unexpected_o = err_q;
    assign reads_issued_o   = rd_cnt_q;
    assign writes_issued_o  = wr_cnt_q;

endmodule
